reg_file: RTL and testbench

- Integer register file for the SimplyTRV core: 32 x 32-bit architectural registers, one synchronous write port, two combinational read ports.
- Sits directly upstream of the 32-input read-select mux. Each read port drives one mux instance; the mux output feeds decode/ALU operands.
- Owns a post-reset clearing sequencer that zeroes every register and then raises ready.

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_mux.sv | 13 +
 rtl/reg_file.sv | 123 ++++++++++++
 tb/tb_reg_file.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the SimplyTRV integer register file.
// Optional build macro used by reg_file: REGFILE_BYPASS_EN (write-to-read forwarding).
package reg_file_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    localparam logic [AW-1:0]   REG_ZERO  = 5'd0;
    localparam logic [AW-1:0]   CLR_FIRST = 5'd1;
    localparam logic [AW-1:0]   REG_LAST  = 5'(NREGS - 1);
    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_mux.sv
// 32-input word mux: selects one XLEN-bit word out of a flattened array.
// Word k occupies bits [k*XLEN +: XLEN] of i_data.
module mux
    import reg_file_pkg::*;
(
    input  logic [NREGS*XLEN-1:0] i_data,
    input  logic [AW-1:0]         i_sel,
    output logic [XLEN-1:0]       o_data
);

    assign o_data = i_data[i_sel*XLEN +: XLEN];

endmodule : mux

// File: rtl/reg_file.sv
// SimplyTRV integer register file: 32 x XLEN, one synchronous write port,
// two combinational read ports, and a post-reset clearing sequencer.
// Build macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module reg_file
    import reg_file_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    output logic            ready
);

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_ready;

    // x0 is hard-wired zero, so it has no storage.
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    logic                  w_clr_en;
    logic                  w_wr_en;
    logic                  w_read_en;
    logic                  w_byp1;
    logic                  w_byp2;
    logic [NREGS*XLEN-1:0] w_mux_in;
    logic [XLEN-1:0]       w_mux1;
    logic [XLEN-1:0]       w_mux2;

    // State register: synchronous reset re-enters INIT; clr_idx walks x1..x31.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_clr_idx <= CLR_FIRST;
            r_ready   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == ST_RUN);
            // Increment from x31 is never needed: the move to RUN fires first.
            if (w_clr_en && (r_clr_idx != REG_LAST)) begin
                r_clr_idx <= r_clr_idx + AW'(1);
            end
        end
    end

    // Next-state logic: leave INIT on the edge that clears x31.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT: if (r_clr_idx == REG_LAST) w_next_state = ST_RUN;
            ST_RUN:  w_next_state = ST_RUN;
            default: w_next_state = ST_INIT;
        endcase
    end

    // Output decode: clear/write strobes, read gating and optional forwarding.
    always_comb begin
        w_clr_en  = (r_state == ST_INIT);
        w_wr_en   = we && r_ready && (waddr != REG_ZERO);
        w_read_en = rst_n && (r_state == ST_RUN);
`ifdef REGFILE_BYPASS_EN
        w_byp1    = w_wr_en && (waddr == raddr1);
        w_byp2    = w_wr_en && (waddr == raddr2);
`else
        w_byp1    = 1'b0;
        w_byp2    = 1'b0;
`endif
    end

    // Storage: the sequencer clears one register per INIT edge, otherwise accept writes.
    // NOTE: the array has no reset branch; the clearing sequencer zeroes it instead,
    // which keeps it mappable to plain storage without a wide reset fan-out.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clr_en) begin
                r_regs[r_clr_idx] <= ZERO_WORD;
            end else if (w_wr_en) begin
                r_regs[waddr] <= wdata;
            end
        end
    end

    // Flatten storage onto the mux array port; slot 0 stays ZERO_WORD for x0.
    always_comb begin
        w_mux_in = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_mux_in[i*XLEN +: XLEN] = r_regs[i];
        end
    end

    mux u_mux1 (
        .i_data (w_mux_in),
        .i_sel  (raddr1),
        .o_data (w_mux1)
    );

    mux u_mux2 (
        .i_data (w_mux_in),
        .i_sel  (raddr2),
        .o_data (w_mux2)
    );

    // Read ports: zero during reset/INIT, forwarded write data when bypass hits.
    always_comb begin
        rdata1 = ZERO_WORD;
        rdata2 = ZERO_WORD;
        if (w_read_en) begin
            rdata1 = w_byp1 ? wdata : w_mux1;
            rdata2 = w_byp2 ? wdata : w_mux2;
        end
    end

    assign ready = r_ready;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: scoreboard of expected read data,
// one task per scenario. Inputs change on the falling edge; outputs are
// sampled shortly after, away from the rising edge.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        ready;

    typedef struct {
        int          port;
        logic [31:0] val;
        string       tag;
    } sb_item_t;

    sb_item_t    sb_q [$];
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;

    reg_file dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] port_val(input int port);
        return (port == 1) ? rdata1 : rdata2;
    endfunction

    task automatic push(input int port, input logic [31:0] val, input string tag);
        sb_item_t it;
        it.port = port;
        it.val  = val;
        it.tag  = tag;
        sb_q.push_back(it);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic test_reset();
        sb_item_t    it;
        logic [31:0] obs;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = 5'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        push(1, 32'h0, "reset_hold_rdata1");
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_hold_ready: got %b expected 0", ready); end
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ready !== (k == 31)) begin
                errors++; $display("FAIL reset_ready_edge%0d: got %b expected %b", k, ready, (k == 31));
            end
            push(1, 32'h0, "init_rdata1_x5");
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front(); obs = port_val(it.port); checks++;
                if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
            end
        end
        clear_model();
    endtask

    task automatic test_write_readback();
        sb_item_t    it;
        logic [31:0] obs;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1; waddr = 5'(i); wdata = 32'h1000_0000 + 32'(i);
            @(posedge clk);
            model[i] = 32'h1000_0000 + 32'(i);
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            push(1, model[i], "readback_p1");
            push(2, model[31 - i], "readback_p2");
            #1;
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front(); obs = port_val(it.port); checks++;
                if (obs !== it.val) begin errors++; $display("FAIL %s idx%0d: got %h expected %h", it.tag, i, obs, it.val); end
            end
        end
        raddr1 = 5'd17; raddr2 = 5'd17;
        push(1, model[17], "same_addr_p1");
        push(2, model[17], "same_addr_p2");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
    endtask

    task automatic test_x0();
        sb_item_t    it;
        logic [31:0] obs;
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF; raddr1 = 5'd0; raddr2 = 5'd0;
        push(1, 32'h0, "x0_same_cycle_p1");
        push(2, 32'h0, "x0_same_cycle_p2");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
        @(negedge clk);
        we = 1'b0;
        push(1, 32'h0, "x0_next_cycle_p1");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
    endtask

    task automatic test_same_cycle();
        sb_item_t    it;
        logic [31:0] obs;
        @(negedge clk);
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5; raddr1 = 5'd3; raddr2 = 5'd4;
        push(1, BYPASS ? 32'hA5A5_A5A5 : model[3], "rw_same_cycle_p1");
        push(2, model[4], "rw_other_port_p2");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
        @(negedge clk);
        model[3] = 32'hA5A5_A5A5;
        we = 1'b1; waddr = 5'd4; wdata = 32'h5A5A_0F0F; raddr1 = 5'd3; raddr2 = 5'd4;
        push(1, 32'hA5A5_A5A5, "rw_next_cycle_p1");
        push(2, BYPASS ? 32'h5A5A_0F0F : model[4], "rw_same_cycle_p2");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
        @(negedge clk);
        model[4] = 32'h5A5A_0F0F;
        we = 1'b0;
        push(2, 32'h5A5A_0F0F, "rw_next_cycle_p2");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
    endtask

    task automatic test_mid_run_reset();
        sb_item_t    it;
        logic [31:0] obs;
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_1234;
        @(negedge clk);
        model[9] = 32'h0000_1234;
        we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd1;
        push(1, model[9], "midrst_loaded_x9");
        push(2, model[1], "midrst_loaded_x1");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
        @(negedge clk);
        rst_n = 1'b0; we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFF;
        push(1, 32'h0, "midrst_low_p1");
        push(2, 32'h0, "midrst_low_p2");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
        @(negedge clk);
        rst_n = 1'b1; we = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_drop: got %b expected 0", ready); end
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ready !== (k == 31)) begin
                errors++; $display("FAIL midrst_ready_edge%0d: got %b expected %b", k, ready, (k == 31));
            end
        end
        clear_model();
        push(1, model[9], "midrst_recleared_x9");
        push(2, model[1], "midrst_recleared_x1");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
    endtask

    task automatic test_early_write_drop();
        sb_item_t    it;
        logic [31:0] obs;
        @(negedge clk);
        rst_n = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; waddr = 5'd7; wdata = 32'h0000_0055;
        // Hold the write from after x7 is cleared up to the edge that raises ready.
        for (int k = 1; k <= 31; k++) begin
            we = (k >= 8);
            @(posedge clk);
            @(negedge clk);
        end
        we = 1'b0; raddr1 = 5'd7; raddr2 = 5'd7;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL early_ready: got %b expected 1", ready); end
        clear_model();
        push(1, model[7], "early_write_x7_p1");
        push(2, model[7], "early_write_x7_p2");
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); obs = port_val(it.port); checks++;
            if (obs !== it.val) begin errors++; $display("FAIL %s: got %h expected %h", it.tag, obs, it.val); end
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_x0();
        test_same_cycle();
        test_mid_run_reset();
        test_early_write_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_file
